// File: rtl/spi_fifo_pkg.sv
// Shared constants and width helpers for the parametrised SPI data FIFO.
package spi_fifo_pkg;

    localparam int unsigned FIFO_MODE_REG  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

    // Pointer indexes DEPTH entries; level needs one extra bit to hold DEPTH itself.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2(depth);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_fifo_param_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO (slave).
interface spi_fifo_param_if
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) ();
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/spi_fifo_mem.sv
// Unreset DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module spi_fifo_mem
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/spi_fifo_param.sv
// Parametrised synchronous FIFO with level/threshold status, sticky error flags,
// synchronous flush and selectable registered or first-word-fall-through reads.
module spi_fifo_param
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned FWFT      = FIFO_MODE_REG
) (
    input logic             clk,
    input logic             rst,
    spi_fifo_param_if.slave bus
);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              empty_c;
    logic              full_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_rd_data;

    // A write into a full FIFO is allowed when the same cycle pops a word.
    assign empty_c  = (level_q == '0);
    assign full_c   = (level_q == LVL_W'(DEPTH));
    assign rd_acc_c = bus.rd_en && !empty_c;
    assign wr_acc_c = bus.wr_en && (!full_c || bus.rd_en);
    assign mem_we_c = wr_acc_c && !bus.flush && !rst;

    spi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (bus.wr_en && !wr_acc_c) overflow_q  <= 1'b1;
            if (bus.rd_en && !rd_acc_c) underflow_q <= 1'b1;
        end
    end

    assign bus.level        = level_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (level_q >= LVL_W'(AFULL_TH));
    assign bus.almost_empty = (level_q <= LVL_W'(AEMPTY_TH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.rd_data  = empty_c ? '0 : mem_rd_data;
        assign bus.rd_valid = !empty_c;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        // Popped word is captured on the accepting edge; rd_valid marks that one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (bus.flush) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc_c;
                if (rd_acc_c) rd_data_q <= mem_rd_data;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_spi_fifo_param.sv
// Directed bench: one registered-read and one FWFT instance share the same stimulus.
module tb_spi_fifo_param;
    import spi_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    spi_fifo_param_if #(.DATA_W(8), .DEPTH(8)) if_r ();
    spi_fifo_param_if #(.DATA_W(8), .DEPTH(8)) if_f ();

    assign if_r.flush   = flush;
    assign if_r.wr_en   = wr_en;
    assign if_r.wr_data = wr_data;
    assign if_r.rd_en   = rd_en;
    assign if_f.flush   = flush;
    assign if_f.wr_en   = wr_en;
    assign if_f.wr_data = wr_data;
    assign if_f.rd_en   = rd_en;

    spi_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1),
                     .FWFT(FIFO_MODE_REG)) dut_r (.clk(clk), .rst(rst), .bus(if_r));
    spi_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1),
                     .FWFT(FIFO_MODE_FWFT)) dut_f (.clk(clk), .rst(rst), .bus(if_f));

    typedef struct {
        logic       fl, wr, rd;
        logic [7:0] wd;
        logic [3:0] lvl;
        logic       full, empty, af, ae, ovf, unf;
        logic [7:0] rdr;
        logic       vr;
        logic [7:0] rdf;
        logic       vf;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic fl, logic wr, logic rd, logic [7:0] wd, logic [3:0] lvl,
                                logic full, logic empty, logic af, logic ae, logic ovf,
                                logic unf, logic [7:0] rdr, logic vr, logic [7:0] rdf,
                                logic vf);
        vec_t v;
        v.fl = fl; v.wr = wr; v.rd = rd; v.wd = wd; v.lvl = lvl;
        v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
        v.rdr = rdr; v.vr = vr; v.rdf = rdf; v.vf = vf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic st(input string tag, input logic [3:0] lvl, input logic full,
                      input logic empty, input logic af, input logic ae,
                      input logic ovf, input logic unf);
        chk({tag, " r.level"},     8'(if_r.level),   8'(lvl));
        chk({tag, " f.level"},     8'(if_f.level),   8'(lvl));
        chk({tag, " r.full"},      8'(if_r.full),    8'(full));
        chk({tag, " f.full"},      8'(if_f.full),    8'(full));
        chk({tag, " r.empty"},     8'(if_r.empty),   8'(empty));
        chk({tag, " f.empty"},     8'(if_f.empty),   8'(empty));
        chk({tag, " r.afull"},     8'(if_r.almost_full),  8'(af));
        chk({tag, " r.aempty"},    8'(if_r.almost_empty), 8'(ae));
        chk({tag, " r.overflow"},  8'(if_r.overflow),  8'(ovf));
        chk({tag, " f.overflow"},  8'(if_f.overflow),  8'(ovf));
        chk({tag, " r.underflow"}, 8'(if_r.underflow), 8'(unf));
        chk({tag, " f.underflow"}, 8'(if_f.underflow), 8'(unf));
    endtask

    task automatic rdc(input string tag, input logic [7:0] rdr, input logic vr,
                       input logic [7:0] rdf, input logic vf);
        chk({tag, " r.rd_data"},  if_r.rd_data,       rdr);
        chk({tag, " r.rd_valid"}, 8'(if_r.rd_valid),  8'(vr));
        chk({tag, " f.rd_data"},  if_f.rd_data,       rdf);
        chk({tag, " f.rd_valid"}, 8'(if_f.rd_valid),  8'(vf));
    endtask

    task automatic drive(input logic fl, input logic wr, input logic rd, input logic [7:0] wd);
        flush = fl; wr_en = wr; rd_en = rd; wr_data = wd;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;

    initial begin
        //           fl wr rd wd     lvl fu em af ae ov un rdr   vr rdf   vf
        tbl[0]  = mk(0, 1, 0, 8'h01, 1,  0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[1]  = mk(0, 1, 0, 8'h02, 2,  0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[2]  = mk(0, 1, 0, 8'h03, 3,  0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[3]  = mk(0, 1, 0, 8'h04, 4,  0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[4]  = mk(0, 1, 0, 8'h05, 5,  0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[5]  = mk(0, 1, 0, 8'h06, 6,  0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[6]  = mk(0, 1, 0, 8'h07, 7,  0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[7]  = mk(0, 1, 0, 8'h08, 8,  1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h01, 1);
        tbl[8]  = mk(0, 1, 0, 8'h09, 8,  1, 0, 1, 0, 1, 0, 8'h00, 0, 8'h01, 1);
        tbl[9]  = mk(0, 0, 1, 8'h00, 7,  0, 0, 1, 0, 1, 0, 8'h01, 1, 8'h02, 1);
        tbl[10] = mk(0, 0, 1, 8'h00, 6,  0, 0, 1, 0, 1, 0, 8'h02, 1, 8'h03, 1);
        tbl[11] = mk(0, 0, 1, 8'h00, 5,  0, 0, 0, 0, 1, 0, 8'h03, 1, 8'h04, 1);
        tbl[12] = mk(0, 0, 1, 8'h00, 4,  0, 0, 0, 0, 1, 0, 8'h04, 1, 8'h05, 1);
        tbl[13] = mk(0, 0, 1, 8'h00, 3,  0, 0, 0, 0, 1, 0, 8'h05, 1, 8'h06, 1);
        tbl[14] = mk(0, 0, 1, 8'h00, 2,  0, 0, 0, 0, 1, 0, 8'h06, 1, 8'h07, 1);
        tbl[15] = mk(0, 0, 1, 8'h00, 1,  0, 0, 0, 1, 1, 0, 8'h07, 1, 8'h08, 1);
        tbl[16] = mk(0, 0, 1, 8'h00, 0,  0, 1, 0, 1, 1, 0, 8'h08, 1, 8'h00, 0);
        tbl[17] = mk(0, 0, 1, 8'h00, 0,  0, 1, 0, 1, 1, 1, 8'h08, 0, 8'h00, 0);
        tbl[18] = mk(1, 1, 1, 8'h77, 0,  0, 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        tbl[19] = mk(0, 0, 0, 8'h00, 0,  0, 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0);

        rst = 1'b1;
        drive(0, 0, 0, 8'h00);
        repeat (2) step();
        st("reset", 0, 0, 1, 0, 1, 0, 0);
        rdc("reset", 8'h00, 0, 8'h00, 0);
        rst = 1'b0;
        step();

        // Fill to overflow, drain to underflow, then flush with requests pending.
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].wd);
            step();
            st(tag, tbl[i].lvl, tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae,
               tbl[i].ovf, tbl[i].unf);
            rdc(tag, tbl[i].rdr, tbl[i].vr, tbl[i].rdf, tbl[i].vf);
        end

        // Write+read on a full FIFO keeps it full; a lone write then overflows.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 8'(8'h10 + i));
            step();
        end
        st("fill", 8, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 8'hAA);
        step();
        st("full_wr_rd", 8, 1, 0, 1, 0, 0, 0);
        rdc("full_wr_rd", 8'h10, 1, 8'h11, 1);
        drive(0, 1, 0, 8'hEE);
        step();
        st("full_ovf", 8, 1, 0, 1, 0, 1, 0);
        q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            exp_d = q.pop_front();
            chk($sformatf("drain%0d f.head", i), if_f.rd_data, exp_d);
            drive(0, 0, 1, 8'h00);
            step();
            chk($sformatf("drain%0d r.rd_data", i), if_r.rd_data, exp_d);
            chk($sformatf("drain%0d r.rd_valid", i), 8'(if_r.rd_valid), 8'd1);
        end
        st("drained", 0, 0, 1, 0, 1, 1, 0);

        // Write+read on an empty FIFO: write lands, read is rejected.
        drive(0, 1, 1, 8'h55);
        step();
        st("empty_wr_rd", 1, 0, 0, 0, 1, 1, 1);
        rdc("empty_wr_rd", 8'hAA, 0, 8'h55, 1);

        // Steady-state streaming at level 3 across two pointer wraps.
        q = '{8'h55};
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 8'(8'h60 + i));
            q.push_back(8'(8'h60 + i));
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 8'(8'h80 + i));
            exp_d = q.pop_front();
            q.push_back(8'(8'h80 + i));
            step();
            chk($sformatf("stream%0d level", i), 8'(if_r.level), 8'd3);
            chk($sformatf("stream%0d r.rd_data", i), if_r.rd_data, exp_d);
            chk($sformatf("stream%0d r.rd_valid", i), 8'(if_r.rd_valid), 8'd1);
            chk($sformatf("stream%0d f.head", i), if_f.rd_data, q[0]);
        end
        drive(1, 1, 1, 8'hCC);
        step();
        st("flush_mid", 0, 0, 1, 0, 1, 0, 0);
        rdc("flush_mid", 8'h00, 0, 8'h00, 0);

        // Asynchronous reset in the middle of a burst at level 5.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 8'(8'h31 + i));
            step();
        end
        drive(0, 1, 1, 8'h36);
        step();
        st("pre_rst", 5, 0, 0, 0, 0, 0, 0);
        rdc("pre_rst", 8'h31, 1, 8'h32, 1);
        drive(0, 1, 1, 8'h37);
        #1 rst = 1'b1;
        #1;
        st("async_rst", 0, 0, 1, 0, 1, 0, 0);
        rdc("async_rst", 8'h00, 0, 8'h00, 0);
        step();
        st("rst_edge", 0, 0, 1, 0, 1, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 8'h00);
        step();
        st("post_rst", 0, 0, 1, 0, 1, 0, 0);
        rdc("post_rst", 8'h00, 0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
